// File: rtl/vga_timing_ctrl.sv
// VGA scan sequencer: pixel-clock divider, H/V counters, sync/active decode,
// and an IDLE/RUN/STOP handshake that only stops on a frame boundary.
module vga_timing_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter int N        = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [N:0] countH,
   output logic [N:0] countV,
   output logic       pix_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_end,
   output logic       busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CW      = N + 1;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);
   localparam logic [N:0]    C_ONE    = CW'(1);
   localparam logic [N:0]    H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [N:0]    V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [N:0]    H_VIS    = CW'(H_ACTIVE);
   localparam logic [N:0]    V_VIS    = CW'(V_ACTIVE);
   localparam logic [N:0]    HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [N:0]    HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [N:0]    VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [N:0]    VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] STOP = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [DW-1:0] div;
   logic          active;
   logic          h_wrap;
   logic          v_wrap;

   assign active    = (state != IDLE);
   assign busy      = active;
   assign pix_tick  = active && (div == DIV_LAST);
   assign h_wrap    = (countH == H_LAST);
   assign v_wrap    = (countV == V_LAST);
   assign frame_end = pix_tick && h_wrap && v_wrap;

   assign hsync    = ~(active && (countH >= HS_BEG) && (countH < HS_END));
   assign vsync    = ~(active && (countV >= VS_BEG) && (countV < VS_END));
   assign video_on = active && (countH < H_VIS) && (countV < V_VIS);

   // A renewed request in STOP wins over the frame boundary so back-to-back frames never gap
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = STOP;
         STOP:    if (en) state_nxt = RUN;
                  else if (frame_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         div    <= '0;
         countH <= '0;
         countV <= '0;
      end else begin
         state <= state_nxt;
         if (!active || (div == DIV_LAST)) div <= '0;
         else                              div <= div + DIV_ONE;
         // Leaving STOP coincides with frame_end, so the wrap below already returns the counters to 0
         if (!active) begin
            countH <= '0;
            countV <= '0;
         end else if (pix_tick) begin
            if (h_wrap) begin
               countH <= '0;
               if (v_wrap) countV <= '0;
               else        countV <= countV + C_ONE;
            end else begin
               countH <= countH + C_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: default geometry (CLK_DIV=2) for reset/start/line timing,
// and a tiny CLK_DIV=1 geometry for whole-frame, stop and restart behaviour.
module tb_vga_timing_ctrl;

   logic clk;
   int   n_cmp = 0;
   int   n_bad = 0;

   // default-geometry instance
   logic       d_rst, d_en;
   logic [9:0] d_cH, d_cV;
   logic       d_tick, d_hs, d_vs, d_vo, d_fe, d_busy;

   // small-geometry instance: H 4/1/2/1 (8), V 3/1/1/1 (6), CLK_DIV=1
   logic       s_rst, s_en;
   logic [3:0] s_cH, s_cV;
   logic       s_tick, s_hs, s_vs, s_vo, s_fe, s_busy;

   vga_timing_ctrl u_def (
      .clk(clk), .rst(d_rst), .en(d_en), .countH(d_cH), .countV(d_cV),
      .pix_tick(d_tick), .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
      .frame_end(d_fe), .busy(d_busy));

   vga_timing_ctrl #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(1), .N(3)
   ) u_small (
      .clk(clk), .rst(s_rst), .en(s_en), .countH(s_cH), .countV(s_cV),
      .pix_tick(s_tick), .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
      .frame_end(s_fe), .busy(s_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached (n_cmp=%0d)", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic d_idle_check(input string nm, input int ncyc);
      int bad = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk); #1;
         if (d_busy !== 1'b0 || d_tick !== 1'b0 || d_hs !== 1'b1 || d_vs !== 1'b1 ||
             d_vo !== 1'b0 || d_fe !== 1'b0 || d_cH !== 10'd0 || d_cV !== 10'd0) bad++;
      end
      chk(nm, bad, 0);
   endtask

   // Spec-level reference for the small instance: state, position and step counter
   int mst, mh, mv, cyc;

   task automatic s_step();
      logic fe_m;
      logic b;
      @(posedge clk);
      cyc++;
      if (mst == 0) begin
         if (s_en) mst = 1;
      end else begin
         fe_m = (mh == 7 && mv == 5);
         if (mh == 7) begin
            mh = 0;
            mv = (mv == 5) ? 0 : mv + 1;
         end else mh++;
         if (mst == 1) begin
            if (!s_en) mst = 2;
         end else if (s_en) mst = 1;
         else if (fe_m) mst = 0;
      end
      #1;
      b = (mst != 0);
      chk($sformatf("s.countH@%0d", cyc), s_cH, mh);
      chk($sformatf("s.countV@%0d", cyc), s_cV, mv);
      chk($sformatf("s.busy@%0d", cyc), s_busy, b);
      chk($sformatf("s.pix_tick@%0d", cyc), s_tick, b);
      chk($sformatf("s.hsync@%0d", cyc), s_hs, !(b && mh >= 5 && mh <= 6));
      chk($sformatf("s.vsync@%0d", cyc), s_vs, !(b && mv == 4));
      chk($sformatf("s.video_on@%0d", cyc), s_vo, b && mh < 4 && mv < 3);
      chk($sformatf("s.frame_end@%0d", cyc), s_fe, b && mh == 7 && mv == 5);
   endtask

   typedef struct {
      logic en;
      int   h, v;
      logic tick, hs, vs, vo, fe, bsy;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int hs_clk, hs_first, hs_last, vo_off, run, prevH, hold_bad, wrap_prev, wrap_new;
      int fe1, fe2, saw_fe, drop;

      //           en    h  v  tick  hs    vs    vo    fe    busy
      tbl[0]  = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 4, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 6, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 7, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 2, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      d_rst = 1'b1; s_rst = 1'b1; d_en = 1'b0; s_en = 1'b0;
      #1;
      d_rst = 1'b0; s_rst = 1'b0;
      #1;
      chk("rst.countH", d_cH, 0);
      chk("rst.countV", d_cV, 0);
      chk("rst.pix_tick", d_tick, 0);
      chk("rst.hsync", d_hs, 1);
      chk("rst.vsync", d_vs, 1);
      chk("rst.video_on", d_vo, 0);
      chk("rst.frame_end", d_fe, 0);
      chk("rst.busy", d_busy, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      d_rst = 1'b1; s_rst = 1'b1;
      d_idle_check("idle_after_reset", 100);

      // Start: en sampled at edge k
      d_en = 1'b1;
      @(posedge clk); #1;
      chk("start.busy", d_busy, 1);
      chk("start.video_on", d_vo, 1);
      chk("start.countH", d_cH, 0);
      chk("start.pix_tick_k", d_tick, 0);
      @(posedge clk); #1;
      chk("start.pix_tick_k1", d_tick, 1);
      chk("start.countH_k1", d_cH, 0);
      @(posedge clk); #1;
      chk("start.countH_k2", d_cH, 1);
      chk("start.pix_tick_k2", d_tick, 0);

      // One full line at default geometry
      hs_clk = 0; hs_first = -1; hs_last = -1; vo_off = -1;
      run = 1; prevH = 1; hold_bad = 0; wrap_prev = -1; wrap_new = -1;
      for (int i = 0; i < 2000 && d_cV == 10'd0; i++) begin
         @(posedge clk); #1;
         if (int'(d_cH) != prevH) begin
            if (run != 2) hold_bad++;
            if (d_cV == 10'd1) begin
               wrap_prev = prevH;
               wrap_new  = int'(d_cH);
            end
            prevH = int'(d_cH);
            run = 1;
         end else run++;
         if (d_cV == 10'd0) begin
            if (!d_hs) begin
               hs_clk++;
               if (hs_first < 0) hs_first = int'(d_cH);
               hs_last = int'(d_cH);
            end
            if (!d_vo && vo_off < 0) vo_off = int'(d_cH);
         end
      end
      chk("line.hsync_low_clocks", hs_clk, 192);
      chk("line.hsync_first_col", hs_first, 656);
      chk("line.hsync_last_col", hs_last, 751);
      chk("line.video_off_col", vo_off, 640);
      chk("line.wrap_from", wrap_prev, 799);
      chk("line.wrap_to", wrap_new, 0);
      chk("line.hold_violations", hold_bad, 0);
      chk("line.vsync_line1", d_vs, 1);

      // Asynchronous reset mid-line while hsync is low
      for (int i = 0; i < 2000 && d_cH != 10'd700; i++) begin
         @(posedge clk); #1;
      end
      chk("midrst.pre_countH", d_cH, 700);
      chk("midrst.pre_hsync", d_hs, 0);
      #1 d_rst = 1'b0;
      #1;
      chk("midrst.countH", d_cH, 0);
      chk("midrst.countV", d_cV, 0);
      chk("midrst.hsync", d_hs, 1);
      chk("midrst.vsync", d_vs, 1);
      chk("midrst.busy", d_busy, 0);
      chk("midrst.video_on", d_vo, 0);
      @(negedge clk);
      d_en = 1'b0;
      d_rst = 1'b1;
      d_idle_check("idle_after_midrst", 100);

      // Small geometry: directed vectors
      for (int i = 0; i < 12; i++) begin
         s_en = tbl[i].en;
         @(posedge clk); #1;
         chk($sformatf("vec%0d.countH", i), s_cH, tbl[i].h);
         chk($sformatf("vec%0d.countV", i), s_cV, tbl[i].v);
         chk($sformatf("vec%0d.pix_tick", i), s_tick, tbl[i].tick);
         chk($sformatf("vec%0d.hsync", i), s_hs, tbl[i].hs);
         chk($sformatf("vec%0d.vsync", i), s_vs, tbl[i].vs);
         chk($sformatf("vec%0d.video_on", i), s_vo, tbl[i].vo);
         chk($sformatf("vec%0d.frame_end", i), s_fe, tbl[i].fe);
         chk($sformatf("vec%0d.busy", i), s_busy, tbl[i].bsy);
      end

      // Continuous run: frame period
      mst = 1; mh = 2; mv = 1; cyc = 0;
      fe1 = -1; fe2 = -1;
      for (int i = 0; i < 200 && fe2 < 0; i++) begin
         s_step();
         if (s_fe === 1'b1) begin
            if (fe1 < 0) fe1 = cyc;
            else         fe2 = cyc;
         end
      end
      chk("small.frame_period", fe2 - fe1, 48);

      // Graceful stop requested at line 1
      for (int i = 0; i < 100 && !(mv == 1); i++) s_step();
      s_en = 1'b0;
      saw_fe = 0;
      for (int i = 0; i < 100 && s_busy === 1'b1; i++) begin
         s_step();
         if (s_fe === 1'b1) saw_fe = 1;
      end
      chk("stop.saw_frame_end", saw_fe, 1);
      chk("stop.busy", s_busy, 0);
      chk("stop.countH", s_cH, 0);
      chk("stop.countV", s_cV, 0);
      chk("stop.hsync", s_hs, 1);
      chk("stop.vsync", s_vs, 1);
      repeat (3) s_step();

      // Stop at line 1, resume at line 3: no gap into next frame
      s_en = 1'b1;
      s_step();
      for (int i = 0; i < 100 && !(mv == 1); i++) s_step();
      s_en = 1'b0;
      for (int i = 0; i < 100 && !(mv == 3); i++) s_step();
      s_en = 1'b1;
      saw_fe = 0; drop = 0;
      for (int i = 0; i < 100 && saw_fe == 0; i++) begin
         s_step();
         if (s_busy !== 1'b1) drop++;
         if (s_fe === 1'b1) saw_fe = 1;
      end
      chk("resume.saw_frame_end", saw_fe, 1);
      chk("resume.busy_drops", drop, 0);
      s_step();
      chk("resume.busy_next", s_busy, 1);
      chk("resume.countH_next", s_cH, 0);
      chk("resume.countV_next", s_cV, 0);
      chk("resume.pix_tick_next", s_tick, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencing controller for the VGA output path. It generates the horizontal and vertical pixel counters that drive `comparatorH`/`comparatorV` and the downstream pixel generator. It divides the system clock into a pixel tick, decodes the sync and active-video windows, and starts and stops scanning cleanly on frame boundaries under an enable handshake.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CLK_DIV`, 2, system clocks per pixel (≥1)
- `N`, 9, counter MSB index; counters are `[N:0]`, and 2^(N+1) must be ≥ H_TOTAL and ≥ V_TOTAL
- `clk` in 1: system clock; all registers on rising edge
- `rst` in 1: asynchronous, active-low reset
- `en` in 1: scan request; level-sensitive, sampled on `clk`
- `countH` out N+1: current pixel column, 0..H_TOTAL-1
- `countV` out N+1: current line, 0..V_TOTAL-1
- `pix_tick` out 1: one-`clk` pulse per pixel period
- `hsync` out 1: active-low horizontal sync
- `vsync` out 1: active-low vertical sync
- `video_on` out 1: high inside the visible region
- `frame_end` out 1: one-`clk` pulse on the last pixel of a frame
- `busy` out 1: high whenever the FSM is not IDLE

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- FSM states: IDLE, RUN, STOP.
  - IDLE→RUN when `en`=1.
  - RUN→STOP when `en`=0.
  - STOP→RUN when `en`=1. Counters continue without a restart.
  - STOP→IDLE on the `clk` where `frame_end`=1. Counters wrap to 0 on the same edge.
  - RUN with `en`=1 never leaves RUN. Frames repeat back to back.
- Divider `div`:
  - Counts 0..CLK_DIV-1 in RUN and STOP.
  - Held at 0 in IDLE.
  - `pix_tick` = (state≠IDLE) && div==CLK_DIV-1.
  - With CLK_DIV=1, `pix_tick` is high every non-IDLE clock.
- Counter advance happens only on `pix_tick`:
  - countH increments.
  - At countH=H_TOTAL-1, countH wraps to 0 and countV increments.
  - At countV=V_TOTAL-1 together with the countH wrap, countV wraps to 0.
- In IDLE, countH and countV are held at 0.
- Decode is combinational from the registered counters and state:
  - hsync=0 iff state≠IDLE && H_ACTIVE+H_FP ≤ countH < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync=0 iff state≠IDLE && V_ACTIVE+V_FP ≤ countV < V_ACTIVE+V_FP+V_SYNC (default 490..491).
  - video_on=1 iff state≠IDLE && countH<H_ACTIVE && countV<V_ACTIVE.
  - frame_end = pix_tick && countH==H_TOTAL-1 && countV==V_TOTAL-1.

## Timing
- Reset values (immediate on `rst`=0, regardless of `clk`):
  - state=IDLE, div=0, countH=0, countV=0
  - pix_tick=0, hsync=1, vsync=1, video_on=0, frame_end=0, busy=0
- Reset mid-frame aborts the scan immediately. No drain occurs. On reset release, the block stays IDLE until `en`=1 is sampled.
- Start latency:
  - `en` is sampled high at edge k, so state=RUN and busy=1 after edge k.
  - video_on=1 from the cycle after edge k, at (0,0).
  - The first `pix_tick` occurs CLK_DIV clocks after edge k. Pixel (0,0) is therefore presented for a full pixel period.
- Each counter value is held for exactly CLK_DIV clocks.
- Stop completes on a frame boundary. The final frame is always complete, with no truncated sync pulse.
  - busy falls on the edge after `frame_end`.
  - Outputs then return to their reset values.
- `en` toggling inside a frame (RUN↔STOP) does not disturb the counters, the divider or the sync outputs.
- A frame lasts H_TOTAL·V_TOTAL·CLK_DIV clocks; default 840000.

## Test plan
- **Reset:** assert `rst`=0 mid-frame at countH=700, countV=491 → on the same cycle countH=0, countV=0, hsync=1, vsync=1, busy=0. After release with `en`=0, all outputs stay at reset values for 100 clocks.
- **Start:** with defaults, raise `en` → busy=1 one edge later, video_on=1, and the first pix_tick occurs 2 clocks after busy rises. countH reaches 1 after that tick.
- **Horizontal timing:** run one line → hsync low for exactly 96 pixels, from countH=656 through 751. video_on is low from countH=640 onward. countV increments when countH wraps from 799 to 0.
- **Vertical and frame timing:**
  - vsync is low only during lines 490 and 491.
  - frame_end pulses once per 840000 clocks at (799,524).
  - The counters read (0,0) on the next clock.
- **Graceful stop:** drop `en` at line 100 → scanning continues to (799,524), frame_end pulses, then busy=0, hsync=1, vsync=1 and the counters read 0. Re-raising `en` during STOP at line 300 keeps busy=1 and the next frame follows without a gap.
- **CLK_DIV=1, small geometry** (H 4/1/2/1, V 3/1/1/1): pix_tick is continuous, the frame is 48 clocks, hsync is low at countH 5..6, and vsync is low at countV 4.
